// File: rtl/param_dual_port_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port,
// per-byte write enables, selectable read-during-write behaviour and an
// optional post-reset sweep that sets every word to INIT_VALUE.
module param_dual_port_ram #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 7,
  parameter int                    RDW_MODE       = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [DATA_WIDTH/8-1:0]   be,
  input  logic [ADDR_WIDTH-1:0]     write_addr,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic                      re,
  input  logic [ADDR_WIDTH-1:0]     read_addr,
  output logic [DATA_WIDTH-1:0]     q,
  output logic                      q_valid,
  output logic                      busy
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  // Byte enables only make sense for whole bytes, so reject other widths.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("param_dual_port_ram: DATA_WIDTH must be a positive multiple of 8");
  end

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    clr_last;
  logic                    clear_we;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // The sweep ends on the word at the top of the address range; comparing
  // against all-ones avoids needing an extra counter bit.
  assign clr_last = (clr_addr == {ADDR_WIDTH{1'b1}});

  // State register; reset restarts the sweep (or goes straight to IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: CLEAR hands over to IDLE once the last word is written.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = IDLE;
      CLEAR:   if (clr_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: busy flag plus the internal write strobes for each source.
  always_comb begin
    busy     = (state == CLEAR);
    clear_we = (state == CLEAR) && !rst;
    mem_we   = (state == IDLE) && !rst && we;
  end

  // Sweep address counter, advancing once per clear cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + ADDR_WIDTH'(1);
    end
  end

  // Memory array: the sweep has priority; user writes merge per enabled byte.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_addr] <= INIT_VALUE;
    end else if (mem_we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (be[i]) begin
          mem[write_addr][8*i +: 8] <= data[8*i +: 8];
        end
      end
    end
  end

  // Read word selection: in write-first mode a same-address write is
  // bypassed byte by byte so q sees the word as it will be stored.
  always_comb begin
    rd_word = mem[read_addr];
    if (RDW_MODE != 0 && mem_we && (read_addr == write_addr)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (be[i]) begin
          rd_word[8*i +: 8] = data[8*i +: 8];
        end
      end
    end
  end

  // Registered read port; q is held at zero while the sweep runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (state == CLEAR) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (re) begin
      q       <= rd_word;
      q_valid <= 1'b1;
    end else begin
      q_valid <= 1'b0;
    end
  end

endmodule
